// File: rtl/reg_wb_if.sv
// Writeback request, hazard query and bank write-port bundle for reg_wb_unit.
// The slave modport is the unit itself; the master modport is the producer/bank side.
interface reg_wb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              a_valid;
   logic              a_ready;
   logic [IDX_W-1:0]  a_idx;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [IDX_W-1:0]  b_idx;
   logic [DATA_W-1:0] b_data;
   logic [IDX_W-1:0]  q_idx;
   logic              q_hit;
   logic [CNT_W-1:0]  count;
   logic              write_en;
   logic [63:0]       write_address;
   logic [DATA_W-1:0] write_data;

   modport slave (
      input  a_valid, a_idx, a_data, b_valid, b_idx, b_data, q_idx,
      output a_ready, b_ready, q_hit, count, write_en, write_address, write_data
   );

   modport master (
      output a_valid, a_idx, a_data, b_valid, b_idx, b_data, q_idx,
      input  a_ready, b_ready, q_hit, count, write_en, write_address, write_data
   );
endinterface

// File: rtl/reg_wb_unit.sv
// Two-producer writeback FIFO draining onto the register bank write port, with hazard query.
// Optional REG_WB_BYPASS_EN: a request into an empty FIFO writes the bank in the same cycle.
module reg_wb_unit #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DEPTH  = 4
) (
   input logic        clk,
   input logic        rst_n,
   reg_wb_if.slave    bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {GrantA, GrantB} grant_e;

   logic [IDX_W-1:0]  idx_mem_q  [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   grant_e            last_q;

   logic              full, a_rdy, b_rdy, acc, push, pop, bypass, hit;
   logic [IDX_W-1:0]  sel_idx;
   logic [DATA_W-1:0] sel_data;
   logic [PTR_W-1:0]  offset;
   logic [63:0]       addr;

   always_comb begin
      full     = (count_q == CNT_W'(DEPTH));
      a_rdy    = !full && bus.a_valid && (!bus.b_valid || last_q == GrantB);
      b_rdy    = !full && bus.b_valid && (!bus.a_valid || last_q == GrantA);
      acc      = a_rdy || b_rdy;
      sel_idx  = a_rdy ? bus.a_idx : bus.b_idx;
      sel_data = a_rdy ? bus.a_data : bus.b_data;
`ifdef REG_WB_BYPASS_EN
      bypass   = acc && (sel_idx != '0) && (count_q == '0);
`else
      bypass   = 1'b0;
`endif
      // Index-0 requests handshake but are dropped here.
      push     = acc && (sel_idx != '0) && !bypass;
      pop      = (count_q != '0);
   end

   always_comb begin
      addr = '0;
      bus.write_data = '0;
      if (bypass) begin
         addr[IDX_W:1]  = sel_idx;
         bus.write_data = sel_data;
      end else if (pop) begin
         addr[IDX_W:1]  = idx_mem_q[rd_ptr_q];
         bus.write_data = data_mem_q[rd_ptr_q];
      end
      bus.write_address = addr;
      bus.write_en      = pop || bypass;
      bus.a_ready       = a_rdy;
      bus.b_ready       = b_rdy;
      bus.count         = count_q;
   end

   // Entry i is occupied when its distance from the head is below the occupancy.
   always_comb begin
      hit    = 1'b0;
      offset = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         offset = PTR_W'(i) - rd_ptr_q;
         if (({1'b0, offset} < count_q) && (idx_mem_q[i] == bus.q_idx)) hit = 1'b1;
      end
      bus.q_hit = hit && (bus.q_idx != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= GrantB;
         for (int i = 0; i < int'(DEPTH); i++) begin
            idx_mem_q[i]  <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            idx_mem_q[wr_ptr_q]  <= sel_idx;
            data_mem_q[wr_ptr_q] <= sel_data;
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
         if (acc) last_q <= a_rdy ? GrantA : GrantB;
      end
   end
endmodule
